fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Instruction fetch controller that owns the program counter and sequences the combinational `INST_ROM` one word per cycle. It presents `{pc, inst}` pairs to the decode stage through a valid/ready handshake, absorbs downstream stalls, and handles branch/jump redirects and misaligned-target faults. It sits between `INST_ROM` and the CPU decode/control logic.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `ADDR_W`, 32: width of PC, ROM address and `out_pc`.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: leave IDLE and begin fetching.
- `rom_addr`  out  ADDR_W: byte address to `INST_ROM`; always equals the internal PC.
- `rom_inst`  in  32: `INST_ROM` data; combinational from `rom_addr`, same cycle.
- `out_valid`  out  1: output slot holds a fetched instruction.
- `out_ready`  in  1: decode accepts the slot this cycle.
- `out_inst`  out  32: fetched instruction.
- `out_pc`  out  ADDR_W: address of `out_inst`.
- `redirect`  in  1: branch/jump taken; flush and refetch.
- `redirect_pc`  in  ADDR_W: new fetch target.
- `fault`  out  1: misaligned redirect detected; sticky until reset.
- `fetch_count`  out  32: number of completed handshakes (`out_valid && out_ready`).

## Operation
- States: IDLE (2'd0), RUN (2'd1), FAULT (2'd2). Reset → IDLE.
- IDLE: no fetch, `out_valid`=0. `start`=1 → RUN next cycle. `redirect` in IDLE loads PC (aligned target) and stays IDLE; misaligned target → FAULT.
- RUN, per cycle, priority order:
  1. `redirect`=1: `out_valid`←0; if `redirect_pc[1:0]`==0, PC←`redirect_pc`, stay RUN; else PC←`redirect_pc`, → FAULT. The slot's handshake this cycle (if `out_valid && out_ready`) still counts.
  2. Slot free (`!out_valid || out_ready`): `out_inst`←`rom_inst`, `out_pc`←PC, `out_valid`←1, PC←PC+4.
  3. Otherwise (stall): hold PC, slot and outputs unchanged.
- PC arithmetic modulo 2^ADDR_W: 32'hFFFF_FFFC + 4 → 32'h0000_0000, no fault.
- FAULT: `fault`=1, `out_valid`=0, PC frozen, `start`/`redirect`/`out_ready` ignored; exit only via `rst`.
- `fetch_count` increments on every `out_valid && out_ready` cycle in any state, wraps at 2^32.
- `start` in RUN or FAULT is ignored.

## Timing
- Reset values: PC=`RESET_PC`, `rom_addr`=`RESET_PC`, `out_valid`=0, `out_inst`=0, `out_pc`=0, `fault`=0, `fetch_count`=0, state IDLE.
- `rst` asserted mid-operation overrides everything at that edge, including a simultaneous redirect or handshake.
- Latency: `start` at edge N → RUN after N; first `out_valid`=1 after edge N+1 with `out_pc`=`RESET_PC`.
- Sustained throughput 1 instruction/cycle with `out_ready` held high.
- Redirect at edge N → `out_valid`=0 after N; instruction at `redirect_pc` valid after N+1 (one bubble).
- `out_inst`/`out_pc` stable while `out_valid && !out_ready`.
- `fault` rises registered, one cycle after the offending redirect is sampled.

## Structure
- Shared include `cpu_defs.vh`: state encodings, `RESET_PC` default, instruction word width, NOP encoding (32'h0000_0000).
- Single module; no sub-module required. PC register, output slot register, state register and counter all in `fetch_ctrl`.

## Test plan
- Reset, `start` at cycle 2, `out_ready`=1 for 8 cycles → `out_pc` = 0,4,8,…,28 on consecutive cycles, `out_inst` matches ROM words 0–7, `fetch_count`=8.
- Stall: `out_ready`=0 for 3 cycles while `out_pc`=8 → `out_pc`/`out_inst` held, `rom_addr`=12 held, `fetch_count` unchanged; release → `out_pc`=12 next cycle.
- Redirect to 32'h40 while `out_pc`=8 valid → next cycle `out_valid`=0, then `out_pc`=32'h40, 32'h44.
- Redirect to 32'h42 → `fault`=1 next cycle, `out_valid`=0 thereafter, `rom_addr`=32'h42 frozen; `redirect`/`start` ignored until `rst`.
- `RESET_PC`=32'hFFFF_FFF8, run 3 fetches → `out_pc` = FFFF_FFF8, FFFF_FFFC, 0000_0000, `fault`=0.
- `rst` asserted with `redirect`=1 and `out_valid && out_ready` → all outputs at reset values, `fetch_count`=0, state IDLE.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared fetch-stage definitions: state encodings, reset PC default, word width, NOP.
// No timing of its own; pure constants and helpers.
// No flow control involved.
package fetch_ctrl_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

    localparam int          INST_W       = 32;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST     = 32'h0000_0000;

    // A fetch target is legal only on a 4-byte boundary.
    function automatic logic is_word_aligned(input logic [1:0] lsb);
        return (lsb == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: owns the PC, reads the combinational ROM, presents {pc, inst} to decode.
// Latency: start -> first valid slot two edges later; redirect costs one bubble; 1 inst/cycle sustained.
// Backpressure: slot and PC hold while out_valid && !out_ready; redirect always wins over a stall.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [INST_W-1:0] rom_inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [ADDR_W-1:0] out_pc,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              fault,
    output logic [31:0]       fetch_count
);

    logic [1:0]        state;
    logic [ADDR_W-1:0] pc;
    logic              target_ok;

    assign rom_addr  = pc;
    assign fault     = (state == ST_FAULT);
    assign target_ok = is_word_aligned(redirect_pc[1:0]);

    // Handshake counter: counts every accepted slot regardless of state or redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count <= 32'd0;
        end else if (out_valid && out_ready) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end

    // State, PC and output slot sequencing; redirect has priority over fetching.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            pc        <= RESET_PC;
            out_valid <= 1'b0;
            out_inst  <= NOP_INST;
            out_pc    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // A redirect before start just retargets the first fetch.
                    if (redirect) begin
                        pc <= redirect_pc;
                        if (!target_ok) begin
                            state <= ST_FAULT;
                        end else if (start) begin
                            state <= ST_RUN;
                        end
                    end else if (start) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (redirect) begin
                        // Flush the slot; the wrong-path instruction is dropped.
                        out_valid <= 1'b0;
                        pc        <= redirect_pc;
                        if (!target_ok) begin
                            state <= ST_FAULT;
                        end
                    end else if (!out_valid || out_ready) begin
                        out_inst  <= rom_inst;
                        out_pc    <= pc;
                        out_valid <= 1'b1;
                        pc        <= pc + ADDR_W'(4);
                    end
                end
                ST_FAULT: begin
                    // Terminal until reset: PC frozen, nothing presented.
                    out_valid <= 1'b0;
                end
                default: begin
                    // Unreachable encoding: park safely in FAULT.
                    out_valid <= 1'b0;
                    state     <= ST_FAULT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: streaming, stall, redirect, fault, PC wrap, reset override.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Second instance uses a near-top RESET_PC to exercise address wrap.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, out_ready, redirect;
    logic [31:0] redirect_pc;

    logic [31:0] rom_addr, rom_inst, out_inst, out_pc, fetch_count;
    logic        out_valid, fault;
    logic [31:0] rom_addr2, rom_inst2, out_inst2, out_pc2, fetch_count2;
    logic        out_valid2, fault2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    assign rom_inst  = rom(rom_addr);
    assign rom_inst2 = rom(rom_addr2);

    fetch_ctrl dut (
        .clk(clk), .rst(rst), .start(start),
        .rom_addr(rom_addr), .rom_inst(rom_inst),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_pc(out_pc),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .fault(fault), .fetch_count(fetch_count)
    );

    fetch_ctrl #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clk(clk), .rst(rst), .start(start),
        .rom_addr(rom_addr2), .rom_inst(rom_inst2),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_inst(out_inst2), .out_pc(out_pc2),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .fault(fault2), .fetch_count(fetch_count2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset, then start; leaves the first slot (pc=0) valid with count 0.
    task automatic reset_and_start();
        rst = 1'b1; start = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
        step(); step();
        rst = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; out_ready = 1'b1;
        step(); step();
        rst = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++; if (rom_addr !== 32'h0) begin errors++; $display("FAIL reset_rom_addr: got %h want 0", rom_addr); end
        checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_out_pc: got %h want 0", out_pc); end
        checks++; if (out_inst !== 32'h0) begin errors++; $display("FAIL reset_out_inst: got %h want 0", out_inst); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b want 0", fault); end
        checks++; if (fetch_count !== 32'h0) begin errors++; $display("FAIL reset_count: got %0d want 0", fetch_count); end
        checks++; if (rom_addr2 !== 32'hFFFF_FFF8) begin errors++; $display("FAIL reset_pc_param: got %h want fffffff8", rom_addr2); end
    endtask

    task automatic test_stream();
        reset_and_start();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %b want 1", i, out_valid); end
            checks++; if (out_pc !== 32'(4 * i)) begin errors++; $display("FAIL stream_pc[%0d]: got %h want %h", i, out_pc, 32'(4 * i)); end
            checks++; if (out_inst !== rom(32'(4 * i))) begin errors++; $display("FAIL stream_inst[%0d]: got %h want %h", i, out_inst, rom(32'(4 * i))); end
            step();
        end
        checks++; if (fetch_count !== 32'd8) begin errors++; $display("FAIL stream_count: got %0d want 8", fetch_count); end
        checks++; if (out_pc !== 32'd32) begin errors++; $display("FAIL stream_next_pc: got %h want 20", out_pc); end
    endtask

    task automatic test_stall();
        reset_and_start();
        out_ready = 1'b1;
        step(); step();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (out_pc !== 32'd8 || out_valid !== 1'b1) begin errors++; $display("FAIL stall_pc[%0d]: got %h/%b want 8/1", i, out_pc, out_valid); end
            checks++; if (out_inst !== rom(32'd8)) begin errors++; $display("FAIL stall_inst[%0d]: got %h want %h", i, out_inst, rom(32'd8)); end
            checks++; if (rom_addr !== 32'd12) begin errors++; $display("FAIL stall_rom_addr[%0d]: got %h want c", i, rom_addr); end
            checks++; if (fetch_count !== 32'd2) begin errors++; $display("FAIL stall_count[%0d]: got %0d want 2", i, fetch_count); end
        end
        out_ready = 1'b1;
        step();
        checks++; if (out_pc !== 32'd12) begin errors++; $display("FAIL stall_release_pc: got %h want c", out_pc); end
        checks++; if (fetch_count !== 32'd3) begin errors++; $display("FAIL stall_release_count: got %0d want 3", fetch_count); end
    endtask

    task automatic test_redirect();
        reset_and_start();
        out_ready = 1'b1;
        step(); step();
        redirect = 1'b1; redirect_pc = 32'h40;
        step();
        redirect = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL redir_bubble: got %b want 0", out_valid); end
        checks++; if (rom_addr !== 32'h40) begin errors++; $display("FAIL redir_rom_addr: got %h want 40", rom_addr); end
        checks++; if (fetch_count !== 32'd3) begin errors++; $display("FAIL redir_count: got %0d want 3", fetch_count); end
        step();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h40) begin errors++; $display("FAIL redir_first: got %b/%h want 1/40", out_valid, out_pc); end
        checks++; if (out_inst !== rom(32'h40)) begin errors++; $display("FAIL redir_inst: got %h want %h", out_inst, rom(32'h40)); end
        step();
        checks++; if (out_pc !== 32'h44) begin errors++; $display("FAIL redir_second: got %h want 44", out_pc); end
    endtask

    task automatic test_fault();
        reset_and_start();
        out_ready = 1'b1;
        redirect = 1'b1; redirect_pc = 32'h42;
        step();
        redirect = 1'b0;
        checks++; if (fault !== 1'b1) begin errors++; $display("FAIL fault_rise: got %b want 1", fault); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fault_valid: got %b want 0", out_valid); end
        checks++; if (rom_addr !== 32'h42) begin errors++; $display("FAIL fault_rom_addr: got %h want 42", rom_addr); end
        redirect = 1'b1; redirect_pc = 32'h80; start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (fault !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL fault_sticky[%0d]: got %b/%b want 1/0", i, fault, out_valid); end
            checks++; if (rom_addr !== 32'h42) begin errors++; $display("FAIL fault_frozen[%0d]: got %h want 42", i, rom_addr); end
        end
        checks++; if (fetch_count !== 32'd1) begin errors++; $display("FAIL fault_count: got %0d want 1", fetch_count); end
        redirect = 1'b0; start = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (fault !== 1'b0 || rom_addr !== 32'h0) begin errors++; $display("FAIL fault_clear: got %b/%h want 0/0", fault, rom_addr); end
    endtask

    task automatic test_wrap();
        reset_and_start();
        out_ready = 1'b1;
        checks++; if (out_pc2 !== 32'hFFFF_FFF8) begin errors++; $display("FAIL wrap_pc0: got %h want fffffff8", out_pc2); end
        step();
        checks++; if (out_pc2 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc1: got %h want fffffffc", out_pc2); end
        step();
        checks++; if (out_pc2 !== 32'h0000_0000 || out_valid2 !== 1'b1) begin errors++; $display("FAIL wrap_pc2: got %h/%b want 0/1", out_pc2, out_valid2); end
        checks++; if (out_inst2 !== rom(32'h0)) begin errors++; $display("FAIL wrap_inst2: got %h want %h", out_inst2, rom(32'h0)); end
        checks++; if (fault2 !== 1'b0) begin errors++; $display("FAIL wrap_fault: got %b want 0", fault2); end
    endtask

    task automatic test_reset_override();
        reset_and_start();
        out_ready = 1'b1;
        step();
        rst = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
        step();
        rst = 1'b0; redirect = 1'b0;
        checks++; if (out_valid !== 1'b0 || fetch_count !== 32'd0) begin errors++; $display("FAIL rstov_valid_count: got %b/%0d want 0/0", out_valid, fetch_count); end
        checks++; if (out_pc !== 32'h0 || out_inst !== 32'h0) begin errors++; $display("FAIL rstov_slot: got %h/%h want 0/0", out_pc, out_inst); end
        checks++; if (rom_addr !== 32'h0 || fault !== 1'b0) begin errors++; $display("FAIL rstov_pc_fault: got %h/%b want 0/0", rom_addr, fault); end
        step(); step();
        checks++; if (out_valid !== 1'b0 || rom_addr !== 32'h0) begin errors++; $display("FAIL rstov_idle: got %b/%h want 0/0", out_valid, rom_addr); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; out_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_fault();
        test_wrap();
        test_reset_override();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
